handshake_arbiter: RTL and testbench
====================================

Name: handshake_arbiter

Overview:
- Shares one Handshake CDC channel between NUM_REQ requesters in the IClk domain.
- Round-robin arbitration; sequences the push/ready protocol: rising-edge push, ready falls, ready rises again.
- Prepends the winner's index as a tag so the OClk side can demultiplex.
- Sits directly on the input side of Handshake, with DATA_WIDTH = TAG_WIDTH + REQ_DATA_WIDTH.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- REQ_DATA_WIDTH, 30, payload width per requester.
- TAG_WIDTH, 2, requester-index width; must satisfy 2**TAG_WIDTH >= NUM_REQ.
- TIMEOUT_CYCLES, 1024, maximum IClk cycles spent waiting on channel ready per transfer.

Ports:
- i_IClk  in  1  IClk domain clock; only clock.
- i_iReset_N  in  1  synchronous, active-low reset.
- i_iReq  in  NUM_REQ  per-requester request level; held until granted.
- i_iReqData  in  NUM_REQ*REQ_DATA_WIDTH  packed payloads; requester k at bits [k*REQ_DATA_WIDTH +: REQ_DATA_WIDTH].
- o_iGrant  out  NUM_REQ  one-hot, one-cycle pulse: payload captured.
- o_iPush  out  1  to Handshake i_iPush.
- o_iHsData  out  TAG_WIDTH+REQ_DATA_WIDTH  to Handshake i_iData; {tag, payload}.
- i_iHsReady  in  1  from Handshake o_iReady.
- o_iBusy  out  1  high in every state except IDLE.
- o_iTimeout  out  1  sticky error flag.
- i_iClrTimeout  in  1  synchronous clear for o_iTimeout.

Behaviour:
- Reset (sampled on i_IClk while i_iReset_N=0):
  - State is IDLE.
  - o_iGrant=0, o_iPush=0, o_iHsData=0, o_iBusy=0, o_iTimeout=0.
  - Round-robin pointer is NUM_REQ-1, so requester 0 has priority first.
  - Reset mid-transfer aborts at once. Handshake keeps its own state; IDLE's ready check keeps the pair consistent.
- All outputs are registered.
- State IDLE:
  - Leaves only when i_iHsReady=1 and |i_iReq.
  - Winner k is the first asserted request searching from pointer+1 upward, with wrap.
  - Next cycle: state PUSH, o_iPush=1, o_iGrant[k]=1, o_iHsData={k, payload k}, pointer=k.
  - Latency from request to push/grant is 1 cycle.
- State PUSH (exactly 1 cycle):
  - o_iPush=1, giving a single-cycle rising edge.
  - Next state WAIT_LO, o_iPush=0, o_iGrant=0.
- State WAIT_LO:
  - If i_iHsReady=0, go to WAIT_HI.
  - Handshake drops ready the cycle after push, so this normally lasts 1 cycle.
- State WAIT_HI:
  - If i_iHsReady=1, go to IDLE.
  - Back-to-back arbitration is allowed from IDLE in that same next cycle.
- Timeout:
  - 16-bit wait counter clears on entry to PUSH and increments in WAIT_LO and WAIT_HI.
  - Reaching TIMEOUT_CYCLES-1 sets o_iTimeout=1 and forces IDLE.
  - IDLE still requires ready=1 before the next push, so no protocol violation.
- o_iTimeout: stays set until i_iClrTimeout=1. If set and clear coincide, set wins.
- o_iHsData holds its value from PUSH until the next grant. Handshake captures it on the push edge.
- Requests:
  - Requester drops i_iReq or changes payload only after its grant.
  - Holding i_iReq high after a grant is a new request.
  - Requests dropped before grant are simply not served; no error.
- Width rules:
  - Tag = winner index zero-extended to TAG_WIDTH.
  - Unused tag codes are never emitted.
  - Build fails (elaboration check) if 2**TAG_WIDTH < NUM_REQ.

Decomposition:
- Shared package hs_arb_pkg:
  - State enum IDLE/PUSH/WAIT_LO/WAIT_HI, 2-bit encoding 0..3.
  - Timeout counter width constant (16).
- Sub-module rr_pick:
  - Combinational round-robin selector.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, binary index, any.

Test Plan:
- Reset with i_iReq=4'b1111 and ready=1 -> all outputs 0 during reset. First grant after release is 4'b0001, o_iHsData={2'd0, payload0}.
- Single transfer: i_iReq=4'b0100, payload2=30'h1234567, ready=1 -> push and grant 4'b0100 one cycle later, o_iHsData=32'h81234567. Ready low then high returns o_iBusy=0.
- Fairness: all four requests held continuously, ready returning 3 cycles after push -> grant order 0,1,2,3,0,1; no requester granted twice in 4 transfers.
- Ready stuck low: i_iHsReady held 0 after push, TIMEOUT_CYCLES=16 -> o_iTimeout=1 at the 16th wait cycle, state IDLE, no push until ready=1. i_iClrTimeout then clears the flag.
- Reset mid-operation: assert i_iReset_N=0 in WAIT_HI -> next cycle IDLE, o_iPush=0, pointer=3. Next grant goes to lowest asserted requester.
- Channel not ready: ready=0 with i_iReq=4'b0010 -> no push or grant. Ready rising -> grant 4'b0010 one cycle later.

Source files
------------

// File: rtl/handshake_arbiter_pkg.sv
// Shared types for the handshake arbiter: FSM state encoding and wait-counter width.
package hs_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PUSH    = 2'd1,
    WAIT_LO = 2'd2,
    WAIT_HI = 2'd3
  } hs_state_t;

  localparam int TO_CNT_W = 16;

endpackage

// File: rtl/handshake_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request strictly after ptr, with wrap.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // Two passes: indices above ptr first, then the wrapped range up to ptr.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!any && req[j] && (j > int'(ptr))) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!any && req[j] && (j <= int'(ptr))) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/handshake_arbiter.sv
// Round-robin front end for one Handshake CDC channel: picks a requester, emits a
// single-cycle push with {tag, payload}, then waits for ready to fall and rise again.
module handshake_arbiter
  import hs_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int REQ_DATA_WIDTH = 30,
  parameter int TAG_WIDTH      = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                              i_IClk,
  input  logic                              i_iReset_N,
  input  logic [NUM_REQ-1:0]                i_iReq,
  input  logic [NUM_REQ*REQ_DATA_WIDTH-1:0] i_iReqData,
  output logic [NUM_REQ-1:0]                o_iGrant,
  output logic                              o_iPush,
  output logic [TAG_WIDTH+REQ_DATA_WIDTH-1:0] o_iHsData,
  input  logic                              i_iHsReady,
  output logic                              o_iBusy,
  output logic                              o_iTimeout,
  input  logic                              i_iClrTimeout
);

  if (2**TAG_WIDTH < NUM_REQ) begin : g_bad_tag
    $error("handshake_arbiter: TAG_WIDTH too small for NUM_REQ");
  end
  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_nreq
    $error("handshake_arbiter: NUM_REQ must be 2..16");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_to
    $error("handshake_arbiter: TIMEOUT_CYCLES must be 1..65536");
  end

  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  hs_state_t                                state, state_nxt;
  logic [TAG_WIDTH-1:0]                     ptr;
  logic [TO_CNT_W-1:0]                      wcnt;
  logic                                     to_hit;
  logic                                     win;
  logic [NUM_REQ-1:0][REQ_DATA_WIDTH-1:0]   req_data;
  logic [REQ_DATA_WIDTH-1:0]                pick_data;
  logic [NUM_REQ-1:0]                       pick_gnt;
  logic [TAG_WIDTH-1:0]                     pick_idx;
  logic                                     pick_any;

  assign req_data = i_iReqData;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (TAG_WIDTH)
  ) u_pick (
    .req (i_iReq),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    pick_data = '0;
    for (int j = 0; j < NUM_REQ; j++)
      if (pick_gnt[j]) pick_data = req_data[j];
  end

  // Arbitration only while idle and the channel reports ready.
  assign win = (state == IDLE) && i_iHsReady && pick_any;

  always_comb begin
    state_nxt = state;
    to_hit    = 1'b0;
    case (state)
      IDLE:    if (win) state_nxt = PUSH;
      PUSH:    state_nxt = WAIT_LO;
      WAIT_LO: begin
        if (wcnt == TO_LAST) begin
          to_hit    = 1'b1;
          state_nxt = IDLE;
        end else if (!i_iHsReady) begin
          state_nxt = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (i_iHsReady) begin
          state_nxt = IDLE;
        end else if (wcnt == TO_LAST) begin
          to_hit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_IClk) begin
    if (!i_iReset_N) begin
      state      <= IDLE;
      ptr        <= TAG_WIDTH'(NUM_REQ - 1);
      wcnt       <= '0;
      o_iGrant   <= '0;
      o_iPush    <= 1'b0;
      o_iHsData  <= '0;
      o_iBusy    <= 1'b0;
      o_iTimeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      o_iBusy  <= (state_nxt != IDLE);
      o_iPush  <= win;
      o_iGrant <= win ? pick_gnt : '0;
      if (win) begin
        ptr       <= pick_idx;
        o_iHsData <= {pick_idx, pick_data};
      end
      if (win)
        wcnt <= '0;
      else if (state == WAIT_LO || state == WAIT_HI)
        wcnt <= wcnt + 1'b1;
      // A timeout in the same cycle as a clear keeps the flag set.
      if (to_hit)
        o_iTimeout <= 1'b1;
      else if (i_iClrTimeout)
        o_iTimeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_handshake_arbiter.sv
// Scoreboard bench for handshake_arbiter: a transaction-level model predicts each cycle's outputs.
module tb_handshake_arbiter;

  localparam int N  = 4;
  localparam int DW = 30;
  localparam int TW = 2;
  localparam int T  = 16;

  typedef struct {
    logic [N-1:0]     grant;
    logic             push;
    logic             busy;
    logic             to;
    logic [TW+DW-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req;
  logic [DW-1:0]     pay [N];
  logic [N*DW-1:0]   req_data;
  logic              ready;
  logic              clr_to;
  logic [N-1:0]      grant;
  logic              push;
  logic [TW+DW-1:0]  hs_data;
  logic              busy;
  logic              timeout;

  int checks   = 0;
  int failures = 0;
  exp_t q[$];

  // transaction-level model
  bit               m_busy;
  bit               m_push;
  bit               m_seen_low;
  int               m_waits;
  int               m_ptr;
  bit               m_to;
  logic [TW+DW-1:0] m_data;
  int               m_gnt = -1;

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int k = 0; k < N; k++) req_data[k*DW +: DW] = pay[k];
  end

  handshake_arbiter #(
    .NUM_REQ        (N),
    .REQ_DATA_WIDTH (DW),
    .TAG_WIDTH      (TW),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .i_IClk        (clk),
    .i_iReset_N    (rst_n),
    .i_iReq        (req),
    .i_iReqData    (req_data),
    .o_iGrant      (grant),
    .o_iPush       (push),
    .o_iHsData     (hs_data),
    .i_iHsReady    (ready),
    .o_iBusy       (busy),
    .o_iTimeout    (timeout),
    .i_iClrTimeout (clr_to)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Predict outputs after the coming edge from the inputs about to be sampled.
  task automatic step_model();
    exp_t e;
    bit   to_now;
    to_now = 1'b0;
    m_gnt  = -1;
    if (!rst_n) begin
      m_busy = 1'b0; m_push = 1'b0; m_ptr = N - 1; m_to = 1'b0; m_data = '0;
    end else begin
      if (m_busy) begin
        if (m_push) begin
          m_push = 1'b0; m_seen_low = 1'b0; m_waits = 0;
        end else begin
          m_waits++;
          if (m_seen_low && ready) m_busy = 1'b0;
          else if (m_waits == T) begin m_busy = 1'b0; to_now = 1'b1; end
          else if (!ready) m_seen_low = 1'b1;
        end
      end else if (ready && req != '0) begin
        for (int i = 1; i <= N; i++) begin
          if (m_gnt < 0 && req[(m_ptr + i) % N]) m_gnt = (m_ptr + i) % N;
        end
        m_ptr  = m_gnt;
        m_busy = 1'b1;
        m_push = 1'b1;
        m_data = {TW'(m_gnt), pay[m_gnt]};
      end
      if (to_now) m_to = 1'b1;
      else if (clr_to) m_to = 1'b0;
    end
    e.grant = (m_gnt >= 0) ? N'(1 << m_gnt) : '0;
    e.push  = (m_gnt >= 0);
    e.busy  = m_busy;
    e.to    = m_to;
    e.data  = m_data;
    q.push_back(e);
  endtask

  // One clock: release last winner, apply inputs, predict, advance to next negedge.
  task automatic drive_cycle(input bit rn, input logic [N-1:0] add, input bit rdy,
                             input bit clr, input bit keep);
    if (m_gnt >= 0) begin
      if (!keep) req[m_gnt] = 1'b0;
      pay[m_gnt] = DW'($urandom);
    end
    req    = req | add;
    rst_n  = rn;
    ready  = rdy;
    clr_to = clr;
    step_model();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    req = '0;
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  // PUSH edge, ready low, ready high -> back to idle.
  task automatic finish_xfer();
    drive_cycle(1'b1, '0, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, '0, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, '0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty: got no expectation at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("sb_grant",   32'(grant),   32'(e.grant));
        chk("sb_push",    32'(push),    32'(e.push));
        chk("sb_busy",    32'(busy),    32'(e.busy));
        chk("sb_timeout", 32'(timeout), 32'(e.to));
        chk("sb_data",    32'(hs_data), 32'(e.data));
      end
    end
  end

  initial begin : stim
    logic [DW-1:0] p0;
    logic [N-1:0]  add;
    int            stuck;
    int            order [6];
    order = '{0, 1, 2, 3, 0, 1};
    for (int k = 0; k < N; k++) pay[k] = DW'($urandom);
    req = '0; rst_n = 1'b0; ready = 1'b1; clr_to = 1'b0;

    // reset with all requests pending
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_push", 32'(push), 32'h0);
    chk("rst_data", 32'(hs_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    p0 = pay[0];
    drive_cycle(1'b1, '0, 1'b1, 1'b0, 1'b0);
    chk("first_grant", 32'(grant), 32'h1);
    chk("first_data", 32'(hs_data), 32'({2'd0, p0}));

    // single transfer from requester 2
    reset_dut();
    pay[2] = 30'h1234567;
    drive_cycle(1'b1, 4'b0100, 1'b1, 1'b0, 1'b0);
    chk("single_grant", 32'(grant), 32'h4);
    chk("single_push", 32'(push), 32'h1);
    chk("single_data", 32'(hs_data), 32'h81234567);
    finish_xfer();
    chk("single_idle", 32'(busy), 32'h0);

    // fairness: all requests held, ready back 3 cycles after push
    reset_dut();
    for (int t = 0; t < 6; t++) begin
      drive_cycle(1'b1, 4'b1111, 1'b1, 1'b0, 1'b1);
      chk("fair_order", 32'(grant), 32'(1 << order[t]));
      drive_cycle(1'b1, '0, 1'b0, 1'b0, 1'b1);
      drive_cycle(1'b1, '0, 1'b0, 1'b0, 1'b1);
      drive_cycle(1'b1, '0, 1'b1, 1'b0, 1'b1);
    end

    // ready stuck low -> timeout; clear coinciding with set loses
    reset_dut();
    drive_cycle(1'b1, 4'b0001, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) drive_cycle(1'b1, '0, 1'b0, 1'b0, 1'b0);
    chk("to_not_yet", 32'(timeout), 32'h0);
    chk("to_still_busy", 32'(busy), 32'h1);
    drive_cycle(1'b1, '0, 1'b0, 1'b1, 1'b0);
    chk("to_set", 32'(timeout), 32'h1);
    chk("to_idle", 32'(busy), 32'h0);
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);
    chk("to_no_push", 32'(push), 32'h0);
    drive_cycle(1'b1, '0, 1'b1, 1'b0, 1'b0);
    chk("to_regrant", 32'(grant), 32'h2);
    chk("to_sticky", 32'(timeout), 32'h1);
    finish_xfer();
    drive_cycle(1'b1, '0, 1'b1, 1'b1, 1'b0);
    chk("to_cleared", 32'(timeout), 32'h0);

    // reset in WAIT_HI, then lowest request wins
    reset_dut();
    drive_cycle(1'b1, 4'b0100, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, '0, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, '0, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("midrst_push", 32'(push), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    drive_cycle(1'b1, 4'b1010, 1'b1, 1'b0, 1'b0);
    chk("midrst_grant", 32'(grant), 32'h2);
    finish_xfer();

    // channel not ready holds off arbitration
    reset_dut();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);
    chk("nrdy_no_grant", 32'(grant), 32'h0);
    chk("nrdy_no_push", 32'(push), 32'h0);
    drive_cycle(1'b1, '0, 1'b1, 1'b0, 1'b0);
    chk("nrdy_grant", 32'(grant), 32'h2);
    finish_xfer();

    // randomized traffic
    reset_dut();
    stuck = 0;
    for (int c = 0; c < 2000; c++) begin
      add = N'($urandom) & N'($urandom);
      if ($urandom_range(0, 99) == 0) stuck = 20;
      if ($urandom_range(0, 99) == 0) begin
        int k;
        k = $urandom_range(0, N - 1);
        if (k != m_gnt) req[k] = 1'b0;
      end
      drive_cycle($urandom_range(0, 199) != 0, add,
                  (stuck > 0) ? 1'b0 : ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
      if (stuck > 0) stuck--;
    end

    chk("sb_drained", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
